// File: rtl/fifo_flow_pkg.sv
// rtl/fifo_flow_pkg.sv - shared encodings for the FIFO flow-control writer and monitor
package fifo_flow_pkg;

    localparam int DATA_W_DEF = 4;
    localparam int TIMER_W    = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SEND  = 2'd1,
        ST_PAUSE = 2'd2,
        ST_ERROR = 2'd3
    } state_t;

    // Ordered by precedence: when events coincide the highest encoding wins (error > pause > continue).
    typedef enum logic [1:0] {
        EVT_NONE     = 2'd0,
        EVT_CONTINUE = 2'd1,
        EVT_PAUSE    = 2'd2,
        EVT_ERROR    = 2'd3
    } evt_t;

    function automatic evt_t resolve_evt(input logic i_pause, input logic i_continue, input logic i_error);
        if (i_error)
            return EVT_ERROR;
        else if (i_pause)
            return EVT_PAUSE;
        else if (i_continue)
            return EVT_CONTINUE;
        else
            return EVT_NONE;
    endfunction

endpackage

// File: rtl/fifo_flow_writer_resume_timer.sv
// rtl/fifo_flow_writer_resume_timer.sv - loadable down-counter pacing the restart after continue
module resume_timer
    import fifo_flow_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               i_en,
    input  logic               i_load,
    input  logic [TIMER_W-1:0] i_load_val,
    input  logic               i_clear,
    output logic               o_busy,
    output logic               o_done
);

    logic [TIMER_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_en) begin
            if (i_clear)
                r_count <= '0;
            else if (i_load)
                r_count <= i_load_val;
            else if (r_count != '0)
                r_count <= r_count - 1'b1;
        end
    end

    assign o_busy = (r_count != '0);
    assign o_done = (r_count == TIMER_W'(1));

endmodule

// File: rtl/fifo_flow_writer.sv
// rtl/fifo_flow_writer.sv - producer-side flow-control engine pushing source words into the FIFO
module fifo_flow_writer
    import fifo_flow_pkg::*;
#(
    parameter int DATA_W       = DATA_W_DEF,
    parameter int RESUME_DELAY = 2,
    parameter int CNT_W        = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_init,
    input  logic              i_src_valid,
    input  logic [DATA_W-1:0] i_src_data,
    output logic              o_src_ready,
    input  logic              i_fifo_full,
    input  logic              i_pause_evt,
    input  logic              i_continue_evt,
    input  logic              i_error_evt,
    input  logic [DATA_W-1:0] i_evt_code,
    output logic              o_push,
    output logic [DATA_W-1:0] o_push_data,
    output logic [1:0]        o_state,
    output logic [CNT_W-1:0]  o_words_sent,
    output logic [DATA_W-1:0] o_pause_code,
    output logic [DATA_W-1:0] o_error_code
);

    state_t             r_state;
    state_t             w_next_state;
    evt_t               w_evt;
    logic               w_src_ready;
    logic               w_xfer;
    logic               w_tmr_load;
    logic               w_tmr_clear;
    logic               w_tmr_busy;
    logic               w_tmr_done;
    logic               r_push;
    logic [DATA_W-1:0]  r_push_data;
    logic [CNT_W-1:0]   r_words_sent;
    logic [DATA_W-1:0]  r_pause_code;
    logic [DATA_W-1:0]  r_error_code;

    // Events only exist while enabled; a masked event is dropped, never queued.
    assign w_evt  = i_init ? resolve_evt(i_pause_evt, i_continue_evt, i_error_evt) : EVT_NONE;
    assign w_xfer = i_src_valid && w_src_ready;

    always_ff @(posedge clk) begin
        if (reset)
            r_state <= ST_IDLE;
        else if (i_init)
            r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:  if (i_src_valid) w_next_state = ST_SEND;
            ST_SEND: begin
                if (w_evt == EVT_ERROR)      w_next_state = ST_ERROR;
                else if (w_evt == EVT_PAUSE) w_next_state = ST_PAUSE;
            end
            ST_PAUSE: begin
                if (w_evt == EVT_ERROR)                   w_next_state = ST_ERROR;
                else if (w_evt != EVT_PAUSE && w_tmr_done) w_next_state = ST_SEND;
            end
            default:  w_next_state = r_state;
        endcase
    end

    always_comb begin
        w_src_ready = 1'b0;
        w_tmr_load  = 1'b0;
        w_tmr_clear = 1'b0;
        case (r_state)
            ST_SEND: w_src_ready = i_init && !i_fifo_full && (w_evt != EVT_PAUSE) && (w_evt != EVT_ERROR);
            ST_PAUSE: begin
                w_tmr_clear = (w_evt == EVT_PAUSE) || (w_evt == EVT_ERROR);
                w_tmr_load  = (w_evt == EVT_CONTINUE) && !w_tmr_busy;
            end
            default: ;
        endcase
    end

    resume_timer u_resume_timer (
        .clk        (clk),
        .reset      (reset),
        .i_en       (i_init),
        .i_load     (w_tmr_load),
        .i_load_val (TIMER_W'(RESUME_DELAY)),
        .i_clear    (w_tmr_clear),
        .o_busy     (w_tmr_busy),
        .o_done     (w_tmr_done)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_push       <= 1'b0;
            r_push_data  <= '0;
            r_words_sent <= '0;
            r_pause_code <= '0;
            r_error_code <= '0;
        end else if (i_init) begin
            r_push <= w_xfer;
            if (w_xfer)
                r_push_data <= i_src_data;
            if (r_push && !(&r_words_sent))
                r_words_sent <= r_words_sent + CNT_W'(1);
            if (r_state == ST_SEND || r_state == ST_PAUSE) begin
                if (w_evt == EVT_ERROR)
                    r_error_code <= i_evt_code;
                else if (w_evt == EVT_PAUSE)
                    r_pause_code <= i_evt_code;
            end
        end
    end

    // A word held over a freeze is presented once init returns, so it is delayed, not duplicated.
    assign o_push       = r_push && i_init;
    assign o_push_data  = r_push_data;
    assign o_src_ready  = w_src_ready;
    assign o_state      = r_state;
    assign o_words_sent = r_words_sent;
    assign o_pause_code = r_pause_code;
    assign o_error_code = r_error_code;

endmodule
